// File: rtl/time_set_ctrl_if.sv
// Keypad-to-time-setter bundle: key inputs, running time snapshot, load/status outputs.
// master = keypad/counter side, slave = time_set_ctrl.
interface time_set_ctrl_if;
  logic       key_vaild;
  logic [3:0] key_code;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load;
  logic       edit_mode;
  logic [1:0] edit_field;
  logic       digit_pend;
  logic       err;

  modport master (
    output key_vaild, key_code, cur_hour, cur_min, cur_sec,
    input  set_hour, set_min, set_sec, load, edit_mode, edit_field, digit_pend, err
  );

  modport slave (
    input  key_vaild, key_code, cur_hour, cur_min, cur_sec,
    output set_hour, set_min, set_sec, load, edit_mode, edit_field, digit_pend, err
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Keypad time-setting controller: key event detect plus hour/min/sec edit FSM with commit pulse.
// Optional idle auto-cancel enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StEditT, StEditU} state_e;

  localparam logic [3:0] KeyNext   = 4'hA;
  localparam logic [3:0] KeyCommit = 4'hB;
  localparam logic [3:0] KeyCancel = 4'hC;

  if (TIMEOUT_CYC < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  // Key event detection
  logic       s1_q, s2_q, s3_q;
  logic       samp1_q, samp2_q;
  logic       arm_q;
  logic       evt_q;
  logic [3:0] code_q;
  logic       rise;

  assign rise = s2_q & ~s3_q & arm_q;

  // arm_q blocks an event from a key already held when reset was released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      samp1_q <= 1'b0;
      samp2_q <= 1'b0;
      arm_q   <= 1'b0;
      evt_q   <= 1'b0;
      code_q  <= 4'd0;
    end else begin
      s1_q    <= bus.key_vaild;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      samp1_q <= 1'b1;
      samp2_q <= samp1_q;
      if (samp2_q && !s2_q) begin
        arm_q <= 1'b1;
      end
      evt_q <= rise;
      if (rise) begin
        code_q <= bus.key_code;
      end
    end
  end

  // Edit FSM
  state_e     state_q, state_d;
  logic [1:0] field_q, field_d;
  logic [3:0] tens_q, tens_d;
  logic [4:0] sh_hour_q, sh_hour_d;
  logic [5:0] sh_min_q, sh_min_d;
  logic [5:0] sh_sec_q, sh_sec_d;
  logic [4:0] set_hour_q, set_hour_d;
  logic [5:0] set_min_q, set_min_d;
  logic [5:0] set_sec_q, set_sec_d;
  logic       load_q, load_d;
  logic       err_q, err_d;

  logic       is_digit;
  logic [3:0] limit;
  logic [6:0] val;
  logic [1:0] field_nxt;
  logic       timeout;

`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [31:0] ToLast = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt_q, to_cnt_d;

  assign timeout = (state_q != StRun) && (to_cnt_q == ToLast);

  // Counter runs only while staying in edit; entry and any key event restart it.
  always_comb begin
    to_cnt_d = '0;
    if (state_q != StRun && state_d != StRun && !evt_q) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign is_digit  = (code_q <= 4'd9);
  assign limit     = (field_q == 2'd0) ? 4'd2 : 4'd5;
  assign val       = {3'b000, tens_q} * 7'd10 + {3'b000, code_q};
  assign field_nxt = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    tens_d     = tens_q;
    sh_hour_d  = sh_hour_q;
    sh_min_d   = sh_min_q;
    sh_sec_d   = sh_sec_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    load_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (evt_q && code_q == KeyNext) begin
          sh_hour_d = bus.cur_hour;
          sh_min_d  = bus.cur_min;
          sh_sec_d  = bus.cur_sec;
          field_d   = 2'd0;
          tens_d    = 4'd0;
          state_d   = StEditT;
        end
      end
      StEditT, StEditU: begin
        if (evt_q) begin
          if (is_digit) begin
            if (state_q == StEditT) begin
              if (code_q > limit) begin
                err_d = 1'b1;
              end else begin
                tens_d  = code_q;
                state_d = StEditU;
              end
            end else if (field_q == 2'd0 && val > 7'd23) begin
              err_d = 1'b1;
            end else begin
              unique case (field_q)
                2'd0:    sh_hour_d = val[4:0];
                2'd1:    sh_min_d  = val[5:0];
                default: sh_sec_d  = val[5:0];
              endcase
              field_d = field_nxt;
              tens_d  = 4'd0;
              state_d = StEditT;
            end
          end else if (code_q == KeyNext) begin
            field_d = field_nxt;
            tens_d  = 4'd0;
            state_d = StEditT;
          end else if (code_q == KeyCommit) begin
            set_hour_d = sh_hour_q;
            set_min_d  = sh_min_q;
            set_sec_d  = sh_sec_q;
            load_d     = 1'b1;
            tens_d     = 4'd0;
            state_d    = StRun;
          end else if (code_q == KeyCancel) begin
            tens_d  = 4'd0;
            state_d = StRun;
          end
        end else if (timeout) begin
          tens_d  = 4'd0;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StRun;
      field_q    <= 2'd0;
      tens_q     <= 4'd0;
      sh_hour_q  <= 5'd0;
      sh_min_q   <= 6'd0;
      sh_sec_q   <= 6'd0;
      set_hour_q <= 5'd0;
      set_min_q  <= 6'd0;
      set_sec_q  <= 6'd0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      tens_q     <= tens_d;
      sh_hour_q  <= sh_hour_d;
      sh_min_q   <= sh_min_d;
      sh_sec_q   <= sh_sec_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

  assign bus.set_hour   = set_hour_q;
  assign bus.set_min    = set_min_q;
  assign bus.set_sec    = set_sec_q;
  assign bus.load       = load_q;
  assign bus.err        = err_q;
  assign bus.edit_mode  = (state_q != StRun);
  assign bus.edit_field = field_q;
  assign bus.digit_pend = (state_q == StEditU);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl; the timeout scenario runs only when
// TIME_SET_TIMEOUT_EN is defined.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  localparam logic [3:0] KA = 4'hA, KB = 4'hB, KC = 4'hC;

  int n_checks = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int load_cnt = 0;
  logic [16:0] load_val = '0;

  // Pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.err === 1'b1) err_cnt++;
    if (bus.load === 1'b1) begin
      load_cnt++;
      load_val = {bus.set_hour, bus.set_min, bus.set_sec};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c, input int hold = 3, input int low = 4);
    bus.key_code  = c;
    bus.key_vaild = 1'b1;
    cyc(hold);
    bus.key_vaild = 1'b0;
    cyc(low);
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.cur_hour = h;
    bus.cur_min  = m;
    bus.cur_sec  = s;
  endtask

  task automatic test_reset();
    bus.key_vaild = 1'b1;
    bus.key_code  = KA;
    set_cur(5'd12, 6'd34, 6'd56);
    reset_n = 1'b0;
    cyc(3);
    n_checks++;
    if ({bus.load, bus.err, bus.edit_mode, bus.digit_pend, bus.edit_field} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_status got %b want 000000",
               {bus.load, bus.err, bus.edit_mode, bus.digit_pend, bus.edit_field});
    end
    n_checks++;
    if ({bus.set_hour, bus.set_min, bus.set_sec} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_set got %0d:%0d:%0d want 0:0:0", bus.set_hour, bus.set_min,
               bus.set_sec);
    end
    reset_n = 1'b1;
    cyc(10);
    n_checks++;
    if (bus.edit_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL preheld_key_no_evt edit_mode got %b want 0", bus.edit_mode);
    end
    bus.key_vaild = 1'b0;
    cyc(4);
    press(KA);
    n_checks++;
    if (bus.edit_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL first_press_after_low edit_mode got %b want 1", bus.edit_mode);
    end
    press(KC);
  endtask

  task automatic test_commit();
    set_cur(5'd12, 6'd34, 6'd56);
    err_cnt = 0;
    load_cnt = 0;
    press(KA);
    n_checks++;
    if (bus.edit_mode !== 1'b1 || bus.edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL commit_enter mode/field got %b/%0d want 1/0", bus.edit_mode, bus.edit_field);
    end
    set_cur(5'd1, 6'd1, 6'd1);
    press(4'd1);
    n_checks++;
    if (bus.digit_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_tens digit_pend got %b want 1", bus.digit_pend);
    end
    press(4'd5);
    n_checks++;
    if (bus.digit_pend !== 1'b0 || bus.edit_field !== 2'd1) begin
      n_fail++;
      $display("FAIL commit_units pend/field got %b/%0d want 0/1", bus.digit_pend,
               bus.edit_field);
    end
    press(KB);
    n_checks++;
    if (bus.edit_mode !== 1'b0 || load_cnt !== 1) begin
      n_fail++;
      $display("FAIL commit_load mode/loads got %b/%0d want 0/1", bus.edit_mode, load_cnt);
    end
    n_checks++;
    if (load_val !== {5'd15, 6'd34, 6'd56}) begin
      n_fail++;
      $display("FAIL commit_value got %h want %h", load_val, {5'd15, 6'd34, 6'd56});
    end
    cyc(5);
    n_checks++;
    if ({bus.set_hour, bus.set_min, bus.set_sec} !== {5'd15, 6'd34, 6'd56} || bus.load !== 1'b0)
    begin
      n_fail++;
      $display("FAIL commit_hold set/load got %0d:%0d:%0d/%b want 15:34:56/0", bus.set_hour,
               bus.set_min, bus.set_sec, bus.load);
    end
  endtask

  task automatic test_reject();
    set_cur(5'd12, 6'd34, 6'd56);
    err_cnt = 0;
    load_cnt = 0;
    press(KA);
    press(4'd3);
    n_checks++;
    if (err_cnt !== 1 || bus.edit_field !== 2'd0 || bus.digit_pend !== 1'b0 ||
        bus.edit_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_tens3 err/field/pend/mode got %0d/%0d/%b/%b want 1/0/0/1", err_cnt,
               bus.edit_field, bus.digit_pend, bus.edit_mode);
    end
    press(4'd2);
    press(4'd4);
    n_checks++;
    if (err_cnt !== 2 || bus.digit_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_24 err/pend got %0d/%b want 2/1", err_cnt, bus.digit_pend);
    end
    press(4'd3);
    n_checks++;
    if (err_cnt !== 2 || bus.digit_pend !== 1'b0 || bus.edit_field !== 2'd1) begin
      n_fail++;
      $display("FAIL accept_23 err/pend/field got %0d/%b/%0d want 2/0/1", err_cnt,
               bus.digit_pend, bus.edit_field);
    end
    press(KB);
    n_checks++;
    if (load_cnt !== 1 || load_val !== {5'd23, 6'd34, 6'd56}) begin
      n_fail++;
      $display("FAIL reject_commit loads/value got %0d/%h want 1/%h", load_cnt, load_val,
               {5'd23, 6'd34, 6'd56});
    end
  endtask

  task automatic test_field_cycle();
    logic [1:0] exp_f[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    load_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      press(KA);
      n_checks++;
      if (bus.edit_field !== exp_f[i]) begin
        n_fail++;
        $display("FAIL field_cycle_%0d got %0d want %0d", i, bus.edit_field, exp_f[i]);
      end
    end
    press(KC);
    n_checks++;
    if (bus.edit_mode !== 1'b0 || load_cnt !== 0 ||
        {bus.set_hour, bus.set_min, bus.set_sec} !== {5'd23, 6'd34, 6'd56}) begin
      n_fail++;
      $display("FAIL cancel mode/loads/set got %b/%0d/%0d:%0d:%0d want 0/0/23:34:56",
               bus.edit_mode, load_cnt, bus.set_hour, bus.set_min, bus.set_sec);
    end
  endtask

  task automatic test_held_key();
    set_cur(5'd1, 6'd2, 6'd3);
    err_cnt = 0;
    load_cnt = 0;
    press(KA);
    press(KA);
    press(4'd7, 1000, 4);
    n_checks++;
    if (err_cnt !== 1 || bus.digit_pend !== 1'b0 || bus.edit_field !== 2'd1) begin
      n_fail++;
      $display("FAIL held_key err/pend/field got %0d/%b/%0d want 1/0/1", err_cnt,
               bus.digit_pend, bus.edit_field);
    end
    press(4'hD);
    press(4'hE);
    press(4'hF);
    n_checks++;
    if (err_cnt !== 1 || bus.digit_pend !== 1'b0 || bus.edit_field !== 2'd1 ||
        bus.edit_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL def_ignored err/pend/field/mode got %0d/%b/%0d/%b want 1/0/1/1", err_cnt,
               bus.digit_pend, bus.edit_field, bus.edit_mode);
    end
    press(4'd5);
    press(4'd9);
    n_checks++;
    if (bus.edit_field !== 2'd2 || bus.digit_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL minute_59 field/pend got %0d/%b want 2/0", bus.edit_field, bus.digit_pend);
    end
    press(KB);
    n_checks++;
    if (load_cnt !== 1 || load_val !== {5'd1, 6'd59, 6'd3}) begin
      n_fail++;
      $display("FAIL held_commit loads/value got %0d/%h want 1/%h", load_cnt, load_val,
               {5'd1, 6'd59, 6'd3});
    end
  endtask

  task automatic test_back_to_back();
    set_cur(5'd10, 6'd20, 6'd30);
    load_cnt = 0;
    press(KA, 2, 1);
    press(4'd2, 2, 1);
    press(4'd0, 2, 1);
    press(KB, 2, 1);
    cyc(6);
    n_checks++;
    if (load_cnt !== 1 || load_val !== {5'd20, 6'd20, 6'd30} || bus.edit_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back loads/value/mode got %0d/%h/%b want 1/%h/0", load_cnt,
               load_val, bus.edit_mode, {5'd20, 6'd20, 6'd30});
    end
  endtask

  task automatic test_reset_mid_edit();
    load_cnt = 0;
    press(KA);
    press(4'd1);
    reset_n = 1'b0;
    cyc(2);
    n_checks++;
    if (bus.edit_mode !== 1'b0 || bus.digit_pend !== 1'b0 || load_cnt !== 0 ||
        {bus.set_hour, bus.set_min, bus.set_sec} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid_edit mode/pend/loads/set got %b/%b/%0d/%h want 0/0/0/0",
               bus.edit_mode, bus.digit_pend, load_cnt, {bus.set_hour, bus.set_min, bus.set_sec});
    end
    reset_n = 1'b1;
    cyc(6);
    press(KA);
    n_checks++;
    if (bus.edit_mode !== 1'b1 || bus.edit_field !== 2'd0 || bus.digit_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL reenter_after_reset mode/field/pend got %b/%0d/%b want 1/0/0",
               bus.edit_mode, bus.edit_field, bus.digit_pend);
    end
    press(KC);
  endtask

`ifdef TIME_SET_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    int k;
    load_cnt = 0;
    bus.key_code  = KA;
    bus.key_vaild = 1'b1;
    w = 0;
    while (bus.edit_mode !== 1'b1 && w < 20) begin
      cyc(1);
      w++;
    end
    bus.key_vaild = 1'b0;
    n_checks++;
    if (bus.edit_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_enter edit_mode got %b want 1", bus.edit_mode);
    end
    k = 0;
    while (bus.edit_mode === 1'b1 && k < 300) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (k !== 100 || load_cnt !== 0) begin
      n_fail++;
      $display("FAIL timeout_cycles cycles/loads got %0d/%0d want 100/0", k, load_cnt);
    end
    cyc(4);
    bus.key_code  = KA;
    bus.key_vaild = 1'b1;
    w = 0;
    while (bus.edit_mode !== 1'b1 && w < 20) begin
      cyc(1);
      w++;
    end
    bus.key_vaild = 1'b0;
    for (k = 0; k < 110; ) begin
      cyc(1);
      k++;
      if (k == 96) begin
        bus.key_code  = 4'd1;
        bus.key_vaild = 1'b1;
      end
      if (k == 98) bus.key_vaild = 1'b0;
    end
    n_checks++;
    if (bus.edit_mode !== 1'b1 || bus.digit_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_key_wins mode/pend got %b/%b want 1/1", bus.edit_mode,
               bus.digit_pend);
    end
    press(KC);
  endtask
`endif

  initial begin
    bus.key_vaild = 1'b0;
    bus.key_code  = 4'd0;
    set_cur(5'd0, 6'd0, 6'd0);
    test_reset();
    test_commit();
    test_reject();
    test_field_cycle();
    test_held_key();
    test_back_to_back();
    test_reset_mid_edit();
`ifdef TIME_SET_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
